mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-requester arbiter that shares the processor's single-port 32x16 data memory between the datapath (CPU port) and the program/debug loader (LD port). The CPU has fixed priority, and a starvation counter guarantees the loader a slot. The block sits between `data_path`, the loader and the memory array. It gives the control unit a stall indication so the control unit can freeze the PC while the CPU is waiting for the memory.

## Interface
- `AW`, 5, memory address width
- `DW`, 16, data width
- `MAX_WAIT`, 3, consecutive denied loader cycles before the loader is forced ahead of the CPU (legal range 1-15)

Ports:
- `clk`  in  1  processor clock; all state updates on the rising edge
- `Rst`  in  1  asynchronous, active-high reset
- `cpu_req`  in  1  CPU access request; held with its command until granted
- `cpu_wr`  in  1  1 = write, 0 = read
- `cpu_addr`  in  AW  CPU address
- `cpu_wdata`  in  DW  CPU write data
- `cpu_gnt`  out  1  CPU command accepted at this edge
- `cpu_rdata`  out  DW  CPU read data, registered
- `cpu_rvalid`  out  1  one-cycle pulse; `cpu_rdata` is valid
- `cpu_stall`  out  1  equals `cpu_req & ~cpu_gnt`
- `ld_req`, `ld_wr`, `ld_addr`, `ld_wdata`, `ld_gnt`, `ld_rdata`, `ld_rvalid`: identical to the CPU port, for the loader
- `mem_addr`  out  AW  address to the memory
- `mem_wr`  out  1  write strobe to the memory
- `mem_wdata`  out  DW  write data to the memory
- `mem_rdata`  in  DW  memory read data; valid in the cycle after the address edge (synchronous read)

## Operation
- **Grant decision.** Combinational each cycle, from the request lines and the registered `wait_cnt`:
  - If `ld_req` is high and `wait_cnt == MAX_WAIT`: grant LD.
  - Else if `cpu_req` is high: grant CPU.
  - Else if `ld_req` is high: grant LD.
  - Else: no grant.
- At most one grant is high in any cycle.
- **Memory drive.** `mem_addr`, `mem_wr` and `mem_wdata` come from the granted port.
  - With no grant: `mem_wr = 0`, and `mem_addr`/`mem_wdata` hold the CPU values (don't care).
- **Acceptance.** A transfer is accepted at an edge where `req & gnt` is high.
  - The requester may present a new command in the next cycle.
  - Back-to-back accepts at full rate are legal.
- **Starvation counter `wait_cnt`.**
  - Increments at every edge where `ld_req & ~ld_gnt`, saturating at `MAX_WAIT`.
  - Clears at every LD accept.
  - Holds when `ld_req` is low.
- **Read return pipeline.** A 2-stage tag shift register holds {valid, owner} for each accepted read.
  - Stage 1 is loaded at the accept edge.
  - At the next edge, `mem_rdata` is captured into the owner's `*_rdata`, and that owner's `*_rvalid` is set for exactly one cycle.
  - The non-owner's `*_rdata` holds its previous value.
- Writes produce no `*_rvalid`.
- **Boundaries.**
  - A read immediately following a write to the same address returns the new data; memory write-first ordering is accepted as is.
  - `wait_cnt` saturates and never wraps.
  - A request dropped before it is granted is a protocol violation. The arbiter does not check for it, and no state other than `wait_cnt` depends on it.

## Timing
- Reset (asynchronous, on `Rst` high):
  - `wait_cnt = 0`; tag pipeline cleared.
  - `cpu_rvalid = ld_rvalid = 0`; `cpu_rdata = ld_rdata = 0`.
  - All grants forced to 0 while `Rst` is high, so `mem_wr = 0`.
- Reset mid-operation: in-flight reads are discarded, and no `rvalid` is produced for them after `Rst` is released.
- Grant latency: 0 cycles (a request can be granted in the cycle it is raised).
- Read latency: accept at edge E0 -> `*_rvalid`/`*_rdata` valid after edge E1, for one cycle.
- Throughput: 1 access per cycle, shared between the two ports.
- Worst-case loader wait: `MAX_WAIT` cycles under continuous CPU requests.

## Test plan
- **Reset:** assert `Rst` mid-cycle with a CPU read in flight -> all outputs are 0 immediately; after release, no `cpu_rvalid` pulse appears.
- **CPU write then read:** write 0xBEEF to address 5, then read address 5 on consecutive cycles -> `cpu_gnt` is high both cycles; `cpu_rdata` = 0xBEEF with a one-cycle `cpu_rvalid` after the second edge.
- **Simultaneous requests, counter at 0:**
  - CPU gets the grant and LD waits.
  - `cpu_stall` stays 0 and `ld_gnt` stays 0 for 3 cycles.
  - On the 4th cycle `ld_gnt` = 1 and `cpu_stall` = 1.
- **Loader burst alone:** the loader writes 0x0001..0x0020 to addresses 0..31 -> `ld_gnt` is high every cycle; readback of address 31 returns 0x0020.
- **Interleaved reads:** CPU reads address 2 and LD reads address 3 in alternate cycles -> each `rvalid` goes only to its owner, with the correct data; the non-owner's rdata is unchanged.
- **`MAX_WAIT` = 1 variant:** continuous traffic on both ports -> grants alternate CPU, LD, CPU, LD.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU port, loader port and memory-side signals around mem_port_arbiter.
// slave = the arbiter's view; master = requesters plus memory array.
interface mem_port_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          cpu_req;
  logic          cpu_wr;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_gnt;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_rvalid;
  logic          cpu_stall;

  logic          ld_req;
  logic          ld_wr;
  logic [AW-1:0] ld_addr;
  logic [DW-1:0] ld_wdata;
  logic          ld_gnt;
  logic [DW-1:0] ld_rdata;
  logic          ld_rvalid;

  logic [AW-1:0] mem_addr;
  logic          mem_wr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
    input  ld_req, ld_wr, ld_addr, ld_wdata,
    output ld_gnt, ld_rdata, ld_rvalid,
    output mem_addr, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output cpu_req, cpu_wr, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rdata, cpu_rvalid, cpu_stall,
    output ld_req, ld_wr, ld_addr, ld_wdata,
    input  ld_gnt, ld_rdata, ld_rvalid,
    input  mem_addr, mem_wr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single-port data memory between the CPU (fixed priority) and the loader,
// with a saturating starvation counter that forces a loader slot after MAX_WAIT denials.
module mem_port_arbiter #(
  parameter int AW       = 5,
  parameter int DW       = 16,
  parameter int MAX_WAIT = 3
) (
  input logic               clk,
  input logic               Rst,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic {OWN_CPU, OWN_LD} owner_e;

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0]    wait_cnt;
  logic          ld_force;
  logic          cpu_gnt;
  logic          ld_gnt;
  logic          cpu_acc;
  logic          ld_acc;
  logic [AW-1:0] addr_sel;
  logic [DW-1:0] wdata_sel;

  logic          tag_vld;
  owner_e        tag_own;
  logic          cpu_rvalid_q;
  logic          ld_rvalid_q;
  logic [DW-1:0] cpu_rdata_q;
  logic [DW-1:0] ld_rdata_q;

  // Grants are held low for the whole reset interval, so no write can leak out.
  always_comb begin
    ld_force = bus.ld_req && (wait_cnt == WAIT_LIMIT);
    cpu_gnt  = 1'b0;
    ld_gnt   = 1'b0;
    if (!Rst) begin
      if (ld_force)         ld_gnt  = 1'b1;
      else if (bus.cpu_req) cpu_gnt = 1'b1;
      else if (bus.ld_req)  ld_gnt  = 1'b1;
    end
  end

  assign cpu_acc   = bus.cpu_req & cpu_gnt;
  assign ld_acc    = bus.ld_req & ld_gnt;
  assign addr_sel  = ld_gnt ? bus.ld_addr  : bus.cpu_addr;
  assign wdata_sel = ld_gnt ? bus.ld_wdata : bus.cpu_wdata;

  assign bus.mem_addr  = addr_sel;
  assign bus.mem_wdata = wdata_sel;
  assign bus.mem_wr    = (cpu_acc & bus.cpu_wr) | (ld_acc & bus.ld_wr);
  assign bus.cpu_gnt   = cpu_gnt;
  assign bus.ld_gnt    = ld_gnt;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_gnt;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      wait_cnt <= '0;
    end else if (ld_acc) begin
      wait_cnt <= '0;
    end else if (bus.ld_req && (wait_cnt != WAIT_LIMIT)) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  // Stage 1 tags the accepted read; stage 2 is the owner's rvalid/rdata register.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      tag_vld      <= 1'b0;
      tag_own      <= OWN_CPU;
      cpu_rvalid_q <= 1'b0;
      ld_rvalid_q  <= 1'b0;
      cpu_rdata_q  <= '0;
      ld_rdata_q   <= '0;
    end else begin
      tag_vld      <= (cpu_acc & ~bus.cpu_wr) | (ld_acc & ~bus.ld_wr);
      tag_own      <= ld_acc ? OWN_LD : OWN_CPU;
      cpu_rvalid_q <= tag_vld && (tag_own == OWN_CPU);
      ld_rvalid_q  <= tag_vld && (tag_own == OWN_LD);
      if (tag_vld && (tag_own == OWN_CPU)) cpu_rdata_q <= bus.mem_rdata;
      if (tag_vld && (tag_own == OWN_LD))  ld_rdata_q  <= bus.mem_rdata;
    end
  end

  assign bus.cpu_rvalid = cpu_rvalid_q;
  assign bus.ld_rvalid  = ld_rvalid_q;
  assign bus.cpu_rdata  = cpu_rdata_q;
  assign bus.ld_rdata   = ld_rdata_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: memory model, read-data scoreboard per port,
// and a second instance with MAX_WAIT = 1 for the alternating-grant case.
module tb_mem_port_arbiter;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [15:0] ref_mem [32];
  logic [15:0] mem     [32];
  logic [15:0] exp_cpu [$];
  logic [15:0] exp_ld  [$];
  logic [15:0] cpu_hold;
  logic [15:0] ld_hold;

  mem_port_arbiter_if #(.AW(5), .DW(16)) bus ();
  mem_port_arbiter_if #(.AW(5), .DW(16)) bus1 ();

  mem_port_arbiter #(.AW(5), .DW(16), .MAX_WAIT(3)) u_arb (
    .clk(clk), .Rst(rst), .bus(bus.slave)
  );

  mem_port_arbiter #(.AW(5), .DW(16), .MAX_WAIT(1)) u_arb1 (
    .clk(clk), .Rst(rst), .bus(bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory, write-first on the same address.
  always @(posedge clk) begin
    if (bus.mem_wr) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= bus.mem_wr ? bus.mem_wdata : mem[bus.mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Read-return monitor: pops the scoreboard on rvalid, else checks rdata holds.
  always @(negedge clk) begin
    if (rst) begin
      cpu_hold = '0;
      ld_hold  = '0;
    end else begin
      if (bus.cpu_rvalid) begin
        chk("cpu_rvalid_expected", 32'(exp_cpu.size() > 0), 32'd1);
        if (exp_cpu.size() > 0) cpu_hold = exp_cpu.pop_front();
        chk("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_hold));
      end else begin
        chk("cpu_rdata_hold", 32'(bus.cpu_rdata), 32'(cpu_hold));
      end
      if (bus.ld_rvalid) begin
        chk("ld_rvalid_expected", 32'(exp_ld.size() > 0), 32'd1);
        if (exp_ld.size() > 0) ld_hold = exp_ld.pop_front();
        chk("ld_rdata", 32'(bus.ld_rdata), 32'(ld_hold));
      end else begin
        chk("ld_rdata_hold", 32'(bus.ld_rdata), 32'(ld_hold));
      end
    end
  end

  task automatic step(input logic cr, input logic cw, input logic [4:0] ca, input logic [15:0] cd,
                      input logic lr, input logic lw, input logic [4:0] la, input logic [15:0] ldd,
                      input logic exp_cg, input logic exp_lg, input string tag);
    @(negedge clk);
    bus.cpu_req = cr; bus.cpu_wr = cw; bus.cpu_addr = ca; bus.cpu_wdata = cd;
    bus.ld_req  = lr; bus.ld_wr  = lw; bus.ld_addr  = la; bus.ld_wdata  = ldd;
    #1;
    chk({tag, "/cpu_gnt"},   32'(bus.cpu_gnt),   32'(exp_cg));
    chk({tag, "/ld_gnt"},    32'(bus.ld_gnt),    32'(exp_lg));
    chk({tag, "/cpu_stall"}, 32'(bus.cpu_stall), 32'(cr & ~exp_cg));
    chk({tag, "/mem_wr"},    32'(bus.mem_wr),    32'((cr & cw & exp_cg) | (lr & lw & exp_lg)));
    if (exp_cg || exp_lg)
      chk({tag, "/mem_addr"}, 32'(bus.mem_addr), 32'(exp_lg ? la : ca));
    if (cr && exp_cg) begin
      if (cw) ref_mem[ca] = cd;
      else    exp_cpu.push_back(ref_mem[ca]);
    end
    if (lr && exp_lg) begin
      if (lw) ref_mem[la] = ldd;
      else    exp_ld.push_back(ref_mem[la]);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 5'd0, 16'h0, 0, 0, 5'd0, 16'h0, 0, 0, "idle");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    rst = 1'b1;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.ld_req  = 0; bus.ld_wr  = 0; bus.ld_addr  = '0; bus.ld_wdata  = '0;
    bus1.cpu_req = 0; bus1.cpu_wr = 0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
    bus1.ld_req  = 0; bus1.ld_wr  = 0; bus1.ld_addr  = '0; bus1.ld_wdata  = '0;
    bus1.mem_rdata = '0;

    #3;
    chk("rst/cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
    chk("rst/ld_gnt",     32'(bus.ld_gnt),     32'd0);
    chk("rst/mem_wr",     32'(bus.mem_wr),     32'd0);
    chk("rst/cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("rst/ld_rvalid",  32'(bus.ld_rvalid),  32'd0);
    chk("rst/cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
    chk("rst/ld_rdata",   32'(bus.ld_rdata),   32'd0);
    @(negedge clk);
    rst = 1'b0;

    // CPU write then read of the same address on consecutive cycles
    step(1, 1, 5'd5, 16'hBEEF, 0, 0, 5'd0, 16'h0, 1, 0, "cpu_wr5");
    step(1, 0, 5'd5, 16'h0,    0, 0, 5'd0, 16'h0, 1, 0, "cpu_rd5");
    idle(3);

    // Reset with a CPU read in flight: outputs clear, no late rvalid
    step(1, 0, 5'd5, 16'h0, 0, 0, 5'd0, 16'h0, 1, 0, "cpu_rd_inflight");
    #7;
    bus.cpu_req = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst/cpu_gnt",    32'(bus.cpu_gnt),    32'd0);
    chk("midrst/ld_gnt",     32'(bus.ld_gnt),     32'd0);
    chk("midrst/mem_wr",     32'(bus.mem_wr),     32'd0);
    chk("midrst/cpu_stall",  32'(bus.cpu_stall),  32'd0);
    chk("midrst/cpu_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    chk("midrst/cpu_rdata",  32'(bus.cpu_rdata),  32'd0);
    chk("midrst/ld_rdata",   32'(bus.ld_rdata),   32'd0);
    exp_cpu.delete();
    exp_ld.delete();
    #4;
    rst = 1'b0;
    idle(4);

    // Loader burst fills the whole memory, then reads back the top address
    for (int i = 0; i < 32; i++)
      step(0, 0, 5'd0, 16'h0, 1, 1, 5'(i), 16'(i + 1), 0, 1, "ld_burst");
    step(0, 0, 5'd0, 16'h0, 1, 0, 5'd31, 16'h0, 0, 1, "ld_rd31");
    idle(3);

    // Simultaneous requests: CPU wins three times, then the loader is forced in
    for (int i = 0; i < 3; i++)
      step(1, 0, 5'd5, 16'h0, 1, 0, 5'd3, 16'h0, 1, 0, "both_cpu_wins");
    step(1, 0, 5'd5, 16'h0, 1, 0, 5'd3, 16'h0, 0, 1, "both_ld_forced");
    step(1, 0, 5'd5, 16'h0, 0, 0, 5'd0, 16'h0, 1, 0, "cpu_after_ld");
    idle(3);

    // Interleaved reads: each rvalid only to its owner, the other rdata holds
    for (int i = 0; i < 2; i++) begin
      step(1, 0, 5'd2, 16'h0, 0, 0, 5'd0, 16'h0, 1, 0, "inter_cpu");
      step(0, 0, 5'd0, 16'h0, 1, 0, 5'd3, 16'h0, 0, 1, "inter_ld");
    end
    idle(3);

    // MAX_WAIT = 1 instance under continuous traffic alternates CPU, LD
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bus1.cpu_req = 1; bus1.cpu_wr = 1; bus1.cpu_addr = 5'(k); bus1.cpu_wdata = 16'(k);
      bus1.ld_req  = 1; bus1.ld_wr  = 1; bus1.ld_addr  = 5'(k); bus1.ld_wdata  = 16'(k);
      #1;
      chk("mw1/cpu_gnt", 32'(bus1.cpu_gnt), 32'((k % 2) == 0));
      chk("mw1/ld_gnt",  32'(bus1.ld_gnt),  32'((k % 2) == 1));
    end
    @(negedge clk);
    bus1.cpu_req = 0;
    bus1.ld_req  = 0;
    idle(2);

    chk("cpu_scoreboard_drained", 32'(exp_cpu.size()), 32'd0);
    chk("ld_scoreboard_drained",  32'(exp_ld.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
